// File: rtl/spi_slave_if.sv
// SPI responder bus: serial pins on one side, word-level data port on the other.
// The slave modport is the responder's view; master is the driver/host view.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;

    modport slave (
        input  sclk, cs_n, mosi, tx_data,
        output miso, miso_oe, tx_load, rx_data, rx_valid, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, tx_data,
        input  miso, miso_oe, tx_load, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs_n/mosi, MSB-first shift in and out,
// per-word rx_valid, tx_load reload at word boundaries, frame_err on short frames.
module spi_slave #(
    parameter int DATA_WIDTH = 32,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_if.slave    bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sclk_q;
    logic [2:0]            cs_q;
    logic [1:0]            mosi_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-2:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  first_q;
    logic                  reload_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;

    logic sclk_edge, leading, trailing;
    logic sample_edge, shift_edge;
    logic cs_fall, cs_rise, mosi_s;
    logic start, end_frame, do_sample, do_shift;
    logic word_end, tx_load_c;
    logic [DATA_WIDTH-1:0] rx_word;

    // [1] is the synchronised level, [2] the previous one for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= {3{CPOL}};
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            cs_q   <= {cs_q[1:0], bus.cs_n};
            mosi_q <= {mosi_q[0], bus.mosi};
        end
    end

    assign sclk_edge   = sclk_q[1] ^ sclk_q[2];
    assign leading     = sclk_edge & (sclk_q[1] != CPOL);
    assign trailing    = sclk_edge & (sclk_q[1] == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading : trailing;
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign mosi_s      = mosi_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cs_fall) state_d = ACTIVE;
            ACTIVE: if (cs_rise) state_d = IDLE;
        endcase
    end

    // a cs_n rise masks any sclk edge seen in the same cycle
    always_comb begin
        start     = 1'b0;
        end_frame = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        unique case (state_q)
            IDLE: start = cs_fall;
            ACTIVE: begin
                end_frame = cs_rise;
                do_sample = sample_edge & ~cs_rise;
                do_shift  = shift_edge & ~cs_rise;
            end
        endcase
    end

    assign word_end  = do_sample & (bit_cnt_q == CW'(DATA_WIDTH - 1));
    assign tx_load_c = start | (do_shift & reload_q);
    assign rx_word   = {rx_sh_q, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            reload_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= word_end;
            frame_err_q <= end_frame & (bit_cnt_q != '0);
            if (start) begin
                tx_sh_q   <= bus.tx_data;
                bit_cnt_q <= '0;
                first_q   <= 1'b1;
                reload_q  <= 1'b0;
            end
            if (end_frame) rx_sh_q <= '0;
            if (do_sample) begin
                rx_sh_q <= rx_word[DATA_WIDTH-2:0];
                if (word_end) begin
                    rx_data_q <= rx_word;
                    bit_cnt_q <= '0;
                    reload_q  <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                end
            end
            // with CPHA=1 the MSB is already on miso at the first leading edge
            if (do_shift) begin
                if (reload_q) begin
                    tx_sh_q  <= bus.tx_data;
                    reload_q <= 1'b0;
                end else if (CPHA && first_q) begin
                    first_q <= 1'b0;
                end else begin
                    tx_sh_q <= tx_sh_q << 1;
                end
            end
        end
    end

    assign bus.miso_oe   = ~cs_q[1];
    assign bus.miso      = ~cs_q[1] & tx_sh_q[DATA_WIDTH-1];
    assign bus.tx_load   = tx_load_c;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule
